// File: rtl/deflate_pkg.sv
// rtl/deflate_pkg.sv - shared types and constants for the fixed-Huffman DEFLATE encoder
package deflate_pkg;

  // Encoder control states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_EOB,
    ST_FLUSH,
    ST_DONE
  } state_t;

  // Block header: BFINAL=1 in bit 0, BTYPE=01 (fixed Huffman) in bits 2:1
  localparam logic [2:0] HDR_FIXED_FINAL = 3'b011;
  localparam logic [4:0] HDR_LEN         = 5'd3;

  // End-of-block symbol 256 is seven zero bits in the fixed table
  localparam logic [4:0] EOB_LEN = 5'd7;

  // Fixed literal code bases and the split between 8-bit and 9-bit codes
  localparam logic [7:0] LIT_BASE_LO = 8'h30;
  localparam logic [8:0] LIT_BASE_HI = 9'h190;
  localparam logic [7:0] LIT_SPLIT   = 8'd144;

endpackage

// File: rtl/fixed_huff_lit_enc.sv
// rtl/fixed_huff_lit_enc.sv - combinational fixed-Huffman literal code lookup, bit-reversed for LSB-first packing
module fixed_huff_lit_enc
  import deflate_pkg::*;
(
  input  logic [7:0] i_lit,
  output logic [8:0] o_code,
  output logic [3:0] o_len
);

  logic [7:0] w_lo_code;
  logic [8:0] w_hi_code;
  logic [7:0] w_lo_rev;
  logic [8:0] w_hi_rev;
  logic [7:0] w_hi_off;

  // Canonical codes are defined MSB-first; reversing them lets the packer
  // insert at the low end of the accumulator and still emit the MSB first.
  always_comb begin
    w_hi_off  = i_lit - LIT_SPLIT;
    w_lo_code = LIT_BASE_LO + i_lit;
    w_hi_code = LIT_BASE_HI + {1'b0, w_hi_off};
    w_lo_rev  = '0;
    w_hi_rev  = '0;
    for (int i = 0; i < 8; i++) begin
      w_lo_rev[i] = w_lo_code[7-i];
    end
    for (int i = 0; i < 9; i++) begin
      w_hi_rev[i] = w_hi_code[8-i];
    end
    if (i_lit < LIT_SPLIT) begin
      o_code = {1'b0, w_lo_rev};
      o_len  = 4'd8;
    end else begin
      o_code = w_hi_rev;
      o_len  = 4'd9;
    end
  end

endmodule

// File: rtl/deflate_fixed_enc.sv
// rtl/deflate_fixed_enc.sv - literal-only DEFLATE encoder emitting one final fixed-Huffman block
module deflate_fixed_enc
  import deflate_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       exit,
  input  logic [7:0] data_in,
  input  logic       data_in_vld,
  input  logic       data_in_last,
  output logic       data_in_rdy,
  output logic [7:0] data_out,
  output logic       data_out_vld,
  input  logic       data_out_rdy,
  output logic       encode_finish
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_acc;
  logic [15:0] w_acc_nxt;
  logic [4:0]  r_cnt;
  logic [4:0]  w_cnt_nxt;

  logic [8:0]  w_code;
  logic [3:0]  w_len;
  logic        w_cnt_ge8;
  logic        w_in_hs;
  logic        w_out_hs;
  logic [7:0]  w_mask;

  fixed_huff_lit_enc u_lit_enc (
    .i_lit  (data_in),
    .o_code (w_code),
    .o_len  (w_len)
  );

  // Handshake outputs; in FLUSH the byte below cnt is padded with zeros
  always_comb begin
    w_cnt_ge8     = (r_cnt >= 5'd8);
    data_in_rdy   = (r_state == ST_DATA) && !w_cnt_ge8;
    data_out_vld  = (r_state == ST_FLUSH) ? (r_cnt != 5'd0) : w_cnt_ge8;
    encode_finish = (r_state == ST_DONE);
    w_mask        = 8'hFF;
    if (r_state == ST_FLUSH) begin
      for (int i = 0; i < 8; i++) begin
        w_mask[i] = (r_cnt > 5'(i));
      end
    end
    data_out = r_acc[7:0] & w_mask;
    w_in_hs  = data_in_rdy && data_in_vld;
    w_out_hs = data_out_vld && data_out_rdy;
  end

  // Next state and accumulator update; a drain takes precedence over an insert
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_acc_nxt   = {13'd0, HDR_FIXED_FINAL};
          w_cnt_nxt   = HDR_LEN;
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_out_hs) begin
          w_acc_nxt = r_acc >> 8;
          w_cnt_nxt = r_cnt - 5'd8;
        end else if (w_in_hs) begin
          w_acc_nxt = r_acc | ({7'd0, w_code} << r_cnt);
          w_cnt_nxt = r_cnt + {1'b0, w_len};
          if (data_in_last) begin
            w_state_nxt = ST_EOB;
          end
        end
      end
      ST_EOB: begin
        if (w_out_hs) begin
          w_acc_nxt = r_acc >> 8;
          w_cnt_nxt = r_cnt - 5'd8;
        end else if (!w_cnt_ge8) begin
          // EOB code bits are all zero, so only the count advances
          w_cnt_nxt   = r_cnt + EOB_LEN;
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (w_out_hs) begin
          w_acc_nxt = r_acc >> 8;
          if (w_cnt_ge8 && (r_cnt != 5'd8)) begin
            w_cnt_nxt = r_cnt - 5'd8;
          end else begin
            w_cnt_nxt   = 5'd0;
            w_state_nxt = ST_DONE;
          end
        end else if (r_cnt == 5'd0) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (exit) begin
      w_state_nxt = ST_IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
    end
  end

  // State and accumulator registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_deflate_fixed_enc.sv
// tb/tb_deflate_fixed_enc.sv - self-checking bench for deflate_fixed_enc
module tb_deflate_fixed_enc;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       exit;
  logic [7:0] data_in;
  logic       data_in_vld;
  logic       data_in_last;
  logic       data_in_rdy;
  logic [7:0] data_out;
  logic       data_out_vld;
  logic       data_out_rdy;
  logic       encode_finish;

  int n_vec = 0;
  int n_mis = 0;

  logic [7:0] in_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] ref_q[$];

  typedef struct {
    logic [7:0] lit;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;

  vec_t tbl[5];

  deflate_fixed_enc dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .exit          (exit),
    .data_in       (data_in),
    .data_in_vld   (data_in_vld),
    .data_in_last  (data_in_last),
    .data_in_rdy   (data_in_rdy),
    .data_out      (data_out),
    .data_out_vld  (data_out_vld),
    .data_out_rdy  (data_out_rdy),
    .encode_finish (encode_finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Reference: build the block as a plain bit list from the RFC 1951 rules, then pack LSB-first
  task automatic model(input logic [7:0] d[$]);
    bit bq[$];
    int code;
    int len;
    logic [7:0] b;
    exp_q.delete();
    bq.push_back(1'b1);             // BFINAL
    bq.push_back(1'b1);             // BTYPE=1, LSB first
    bq.push_back(1'b0);
    foreach (d[k]) begin
      if (d[k] < 144) begin
        code = 48 + int'(d[k]);
        len  = 8;
      end else begin
        code = 400 + int'(d[k]) - 144;
        len  = 9;
      end
      for (int i = len - 1; i >= 0; i--) bq.push_back(bit'((code >> i) & 1));
    end
    for (int i = 0; i < 7; i++) bq.push_back(1'b0);
    while (bq.size() % 8 != 0) bq.push_back(1'b0);
    for (int i = 0; i < bq.size(); i += 8) begin
      for (int j = 0; j < 8; j++) b[j] = bq[i+j];
      exp_q.push_back(b);
    end
  endtask

  task automatic cmp_q(input string name);
    int n;
    chk({name, "_len"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({name, "_byte"}, int'(got_q[i]), int'(exp_q[i]));
  endtask

  // Drive one stream from in_q with random output stalls, collecting bytes into got_q
  task automatic run_stream(input int stall_pct, output int fin_cnt);
    int idx;
    int cyc;
    int post;
    bit done;
    bit prev_stall;
    logic [7:0] prev_d;
    idx = 0; cyc = 0; post = 0; done = 0; prev_stall = 0; prev_d = '0;
    fin_cnt = 0;
    got_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rdy_after_start", int'(data_in_rdy), 1);
    while (cyc < 3000) begin
      if (encode_finish) fin_cnt++;
      if (prev_stall) begin
        chk("stall_vld_hold", int'(data_out_vld), 1);
        chk("stall_data_hold", int'(data_out), int'(prev_d));
      end
      if (done) post++;
      if (post >= 4) break;
      if (encode_finish) done = 1;
      data_out_rdy = ($urandom_range(0, 99) >= stall_pct);
      if (data_out_vld && data_out_rdy) got_q.push_back(data_out);
      prev_stall = data_out_vld && !data_out_rdy;
      prev_d     = data_out;
      if (idx < in_q.size()) begin
        data_in_vld  = 1'b1;
        data_in      = in_q[idx];
        data_in_last = (idx == in_q.size() - 1);
        if (data_in_rdy) idx++;
      end else begin
        data_in_vld  = 1'b0;
        data_in_last = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    chk("stream_timeout", int'(cyc >= 3000), 0);
    data_in_vld  = 1'b0;
    data_in_last = 1'b0;
    data_out_rdy = 1'b0;
  endtask

  initial begin
    int fin;
    int idx;
    int hs;
    int cyc;
    int len;
    logic [7:0] abc_ref[$];

    tbl[0] = '{8'h00, 8'h63, 8'h00, 8'h00};
    tbl[1] = '{8'h61, 8'h4B, 8'h04, 8'h00};
    tbl[2] = '{8'hFF, 8'hFB, 8'h0F, 8'h00};
    tbl[3] = '{8'h8F, 8'hEB, 8'h07, 8'h00};
    tbl[4] = '{8'h90, 8'h9B, 8'h00, 8'h00};

    rst = 1'b1; start = 1'b0; exit = 1'b0;
    data_in = '0; data_in_vld = 1'b0; data_in_last = 1'b0; data_out_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_rdy", int'(data_in_rdy), 0);
    chk("rst_out_vld", int'(data_out_vld), 0);
    chk("rst_out", int'(data_out), 0);
    chk("rst_finish", int'(encode_finish), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single-byte table, no stalls
    for (int i = 0; i < 5; i++) begin
      in_q = '{tbl[i].lit};
      run_stream(0, fin);
      exp_q = '{tbl[i].e0, tbl[i].e1, tbl[i].e2};
      cmp_q("tbl");
      chk("tbl_finish_cnt", fin, 1);
    end

    // "abc" unstalled, then stalled: both must match the model and each other
    in_q = '{8'h61, 8'h62, 8'h63};
    model(in_q);
    run_stream(0, fin);
    cmp_q("abc");
    chk("abc_finish_cnt", fin, 1);
    abc_ref = got_q;
    run_stream(50, fin);
    cmp_q("abc_stall");
    exp_q = abc_ref;
    cmp_q("abc_stall_vs_unstalled");
    chk("abc_stall_finish_cnt", fin, 1);

    // Random streams against the reference model
    for (int t = 0; t < 8; t++) begin
      in_q.delete();
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) in_q.push_back(8'($urandom_range(0, 255)));
      model(in_q);
      run_stream(30, fin);
      cmp_q("rand");
      chk("rand_finish_cnt", fin, 1);
    end

    // exit wins over start in IDLE
    @(negedge clk);
    start = 1'b1; exit = 1'b1;
    @(negedge clk);
    start = 1'b0; exit = 1'b0;
    chk("exit_over_start_rdy", int'(data_in_rdy), 0);
    @(negedge clk);

    // Abort after two accepted bytes, then a clean restart
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data_out_rdy = 1'b1;
    idx = 0; cyc = 0;
    in_q = '{8'h61, 8'h62};
    while (idx < 2 && cyc < 50) begin
      data_in_vld  = 1'b1;
      data_in      = in_q[idx];
      data_in_last = 1'b0;
      if (data_in_rdy) idx++;
      @(negedge clk);
      cyc++;
    end
    chk("abort_accept_timeout", int'(cyc >= 50), 0);
    data_in_vld = 1'b0;
    exit = 1'b1;
    @(negedge clk);
    exit = 1'b0;
    data_out_rdy = 1'b0;
    chk("exit_out_vld", int'(data_out_vld), 0);
    chk("exit_in_rdy", int'(data_in_rdy), 0);
    chk("exit_out", int'(data_out), 0);
    in_q = '{8'h00};
    run_stream(0, fin);
    exp_q = '{8'h63, 8'h00, 8'h00};
    cmp_q("restart");
    chk("restart_finish_cnt", fin, 1);

    // Reset while in FLUSH: outputs clear and encode_finish never fires
    fin = 0; hs = 0; cyc = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data_out_rdy = 1'b1;
    idx = 0;
    while (hs < 2 && cyc < 100) begin
      if (encode_finish) fin++;
      if (idx == 0 && data_in_rdy) begin
        data_in_vld = 1'b1; data_in = 8'h00; data_in_last = 1'b1; idx = 1;
      end else begin
        data_in_vld = 1'b0; data_in_last = 1'b0;
      end
      if (data_out_vld) hs++;
      @(negedge clk);
      cyc++;
    end
    chk("flush_reach_timeout", int'(cyc >= 100), 0);
    data_in_vld = 1'b0; data_in_last = 1'b0;
    data_out_rdy = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("flush_rst_in_rdy", int'(data_in_rdy), 0);
    chk("flush_rst_out_vld", int'(data_out_vld), 0);
    chk("flush_rst_out", int'(data_out), 0);
    chk("flush_rst_finish", int'(encode_finish), 0);
    data_out_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (encode_finish) fin++;
      @(negedge clk);
    end
    chk("flush_rst_no_finish", fin, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
